// File: rtl/anti_theft_ctrl_if.sv
// Countdown-timer link between the anti-theft master FSM (master) and the timer (slave).
interface anti_theft_ctrl_if #(
  parameter int W = 4
) ();
  logic         start_timer;
  logic [W-1:0] load_value;
  logic         expired;

  modport master (output start_timer, output load_value, input expired);
  modport slave  (input start_timer, input load_value, output expired);
endinterface

// File: rtl/anti_theft_ctrl.sv
// Anti-theft master FSM: arms, triggers, sounds the siren and drives the countdown timer.
// Optional ANTI_THEFT_BLINK_EN: status_led blinks at 0.5 Hz while ARMED.
module anti_theft_ctrl #(
  parameter int W                   = 4,
  parameter int DEF_ARM_DELAY       = 6,
  parameter int DEF_DRIVER_DELAY    = 8,
  parameter int DEF_PASSENGER_DELAY = 15,
  parameter int DEF_ALARM_ON        = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ignition,
  input  logic                    door_driver,
  input  logic                    door_pass,
  input  logic                    reprogram,
  input  logic [1:0]              time_sel,
  input  logic [W-1:0]            time_value,
  input  logic                    one_hz_enable,
  anti_theft_ctrl_if.master       tmr,
  output logic                    siren,
  output logic                    status_led,
  output logic [2:0]              state_o
);

  typedef enum logic [2:0] {
    ARMED         = 3'd0,
    TRIGGERED     = 3'd1,
    ALARM         = 3'd2,
    ALARM_HOLD    = 3'd3,
    DIS_IGN_ON    = 3'd4,
    DIS_IGN_OFF   = 3'd5,
    DIS_DOOR_OPEN = 3'd6,
    ARM_WAIT      = 3'd7
  } state_t;

  localparam logic [1:0] P_ARM = 2'd0;
  localparam logic [1:0] P_DRV = 2'd1;
  localparam logic [1:0] P_PAS = 2'd2;
  localparam logic [1:0] P_ALM = 2'd3;

  state_t       state_r;
  state_t       nxt_s;
  logic [W-1:0] param_r [4];
  logic         start_r;
  logic [W-1:0] load_r;
  logic         start_s;
  logic [W-1:0] load_s;
  logic         led_s;
  logic         exp_s;
  logic         any_door_s;

  // The timer flag is stale in the cycle its restart is being issued.
  assign exp_s           = tmr.expired & ~start_r;
  assign any_door_s      = door_driver | door_pass;
  assign tmr.start_timer = start_r;
  assign tmr.load_value  = load_r;
  assign state_o         = state_r;

  // Next-state and timer-start decision; ignition > doors > expired everywhere.
  always_comb begin
    nxt_s   = state_r;
    start_s = 1'b0;
    load_s  = load_r;
    case (state_r)
      ARMED: begin
        if (ignition) begin
          nxt_s = DIS_IGN_ON;
        end else if (door_driver) begin
          nxt_s = TRIGGERED; start_s = 1'b1; load_s = param_r[P_DRV];
        end else if (door_pass) begin
          nxt_s = TRIGGERED; start_s = 1'b1; load_s = param_r[P_PAS];
        end else begin
          nxt_s = ARMED;
        end
      end
      TRIGGERED: begin
        if (ignition)   nxt_s = DIS_IGN_ON;
        else if (exp_s) nxt_s = ALARM;
        else            nxt_s = TRIGGERED;
      end
      ALARM: begin
        if (ignition) begin
          nxt_s = DIS_IGN_ON;
        end else if (!any_door_s) begin
          nxt_s = ALARM_HOLD; start_s = 1'b1; load_s = param_r[P_ALM];
        end else begin
          nxt_s = ALARM;
        end
      end
      ALARM_HOLD: begin
        if (ignition)        nxt_s = DIS_IGN_ON;
        else if (any_door_s) nxt_s = ALARM;
        else if (exp_s)      nxt_s = ARMED;
        else                 nxt_s = ALARM_HOLD;
      end
      DIS_IGN_ON: begin
        if (!ignition) nxt_s = DIS_IGN_OFF;
        else           nxt_s = DIS_IGN_ON;
      end
      DIS_IGN_OFF: begin
        if (ignition)         nxt_s = DIS_IGN_ON;
        else if (door_driver) nxt_s = DIS_DOOR_OPEN;
        else                  nxt_s = DIS_IGN_OFF;
      end
      DIS_DOOR_OPEN: begin
        if (ignition) begin
          nxt_s = DIS_IGN_ON;
        end else if (!any_door_s) begin
          nxt_s = ARM_WAIT; start_s = 1'b1; load_s = param_r[P_ARM];
        end else begin
          nxt_s = DIS_DOOR_OPEN;
        end
      end
      ARM_WAIT: begin
        if (ignition)        nxt_s = DIS_IGN_ON;
        else if (any_door_s) nxt_s = DIS_DOOR_OPEN;
        else if (exp_s)      nxt_s = ARMED;
        else                 nxt_s = ARM_WAIT;
      end
      default: begin
        nxt_s = ARMED;
      end
    endcase
  end

`ifdef ANTI_THEFT_BLINK_EN
  // LED level for the next state; blinks on each tick while staying in ARMED.
  always_comb begin
    led_s = 1'b0;
    case (nxt_s)
      ARMED: begin
        if (state_r != ARMED) led_s = 1'b1;
        else if (one_hz_enable) led_s = ~status_led;
        else led_s = status_led;
      end
      TRIGGERED, ALARM, ALARM_HOLD: led_s = 1'b1;
      default: led_s = 1'b0;
    endcase
  end
`else
  logic unused_tick_s;
  assign unused_tick_s = one_hz_enable;

  // LED level for the next state; steady in ARMED.
  always_comb begin
    led_s = 1'b0;
    case (nxt_s)
      ARMED, TRIGGERED, ALARM, ALARM_HOLD: led_s = 1'b1;
      default: led_s = 1'b0;
    endcase
  end
`endif

  // State, parameter table and registered outputs; reprogram overrides everything but rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ARMED;
      param_r[P_ARM]   <= W'(DEF_ARM_DELAY);
      param_r[P_DRV]   <= W'(DEF_DRIVER_DELAY);
      param_r[P_PAS]   <= W'(DEF_PASSENGER_DELAY);
      param_r[P_ALM]   <= W'(DEF_ALARM_ON);
      start_r          <= 1'b0;
      load_r           <= '0;
      siren            <= 1'b0;
      status_led       <= 1'b1;
    end else if (reprogram) begin
      param_r[time_sel] <= time_value;
      state_r           <= ARMED;
      start_r           <= 1'b0;
      load_r            <= load_r;
      siren             <= 1'b0;
      status_led        <= 1'b1;
    end else begin
      state_r    <= nxt_s;
      start_r    <= start_s;
      load_r     <= load_s;
      siren      <= (nxt_s == ALARM) || (nxt_s == ALARM_HOLD);
      status_led <= led_s;
    end
  end

endmodule
